// File: rtl/fg_prog_pkg.sv
// Shared types and constants for the floating-gate island programming sequencer.
package fg_prog_pkg;

    localparam int unsigned PCNT_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StRecover,
        StRelease,
        StDone
    } state_e;

    typedef enum logic {
        MODE_INJECT = 1'b0,
        MODE_ERASE  = 1'b1
    } mode_e;

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter; zero is high in the last cycle of a loaded interval.
module fg_prog_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fg_island_prog_seq.sv
// Program/erase pulse sequencer for one floating-gate crossbar island.
// Optional comparator readback early-exit is enabled by FG_PROG_READBACK_EN.
module fg_island_prog_seq
    import fg_prog_pkg::*;
#(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 17,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned PULSE_CYC  = 16,
    localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ROW_W-1:0]  cmd_row,
    input  logic [COL_W-1:0]  cmd_col,
    input  logic [PCNT_W-1:0] cmd_pulses,
    input  logic              cmd_erase,
    input  logic              cmp_in,
    output logic [ROW_W-1:0]  dec_row,
    output logic [COL_W-1:0]  dec_col,
    output logic [ROWS-1:0]   drain_sel,
    output logic [COLS-1:0]   gate_sel,
    output logic              prog_en,
    output logic              vinj_pulse,
    output logic              vtun_pulse,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PCNT_W-1:0] pulses_used
);

    localparam int unsigned TMR_MAX = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_CYC - 1);

    state_e            state;
    mode_e             mode_q;
    logic [PCNT_W-1:0] n_q;
    logic              err_pend;

    logic              tmr_load;
    logic              tmr_zero;
    logic [TMR_W-1:0]  tmr_val;

    logic              cmd_illegal;
    logic              exhausted;
    logic              last_pulse;
    logic              rb_fail;
    logic [PCNT_W-1:0] pulses_inc;

    assign cmd_illegal = (32'(cmd_row) >= ROWS) || (32'(cmd_col) >= COLS) ||
                         (cmd_pulses == '0);
    assign exhausted   = (pulses_used == n_q);
    assign pulses_inc  = (pulses_used == '1) ? pulses_used : pulses_used + 1'b1;

`ifdef FG_PROG_READBACK_EN
    // Comparator is meaningful only in the last RECOVER cycle, where this is consumed.
    assign last_pulse = exhausted || cmp_in;
    assign rb_fail    = exhausted && !cmp_in;
`else
    logic unused_cmp_in;
    assign unused_cmp_in = cmp_in;
    assign last_pulse    = exhausted;
    assign rb_fail       = 1'b0;
`endif

    assign cmd_ready = (state == StIdle);
    assign busy      = (state != StIdle);

    // Timer is reloaded on every state entry with the length of the state being entered.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LD;
        unique case (state)
            StIdle:    tmr_load = cmd_valid;
            StSetup: begin
                tmr_load = tmr_zero;
                tmr_val  = PULSE_LD;
            end
            StPulse:   tmr_load = tmr_zero;
            StRecover: begin
                tmr_load = tmr_zero;
                if (!last_pulse) begin
                    tmr_val = PULSE_LD;
                end
            end
            default:   tmr_load = 1'b0;
        endcase
    end

    fg_prog_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            mode_q      <= MODE_INJECT;
            n_q         <= '0;
            err_pend    <= 1'b0;
            dec_row     <= '0;
            dec_col     <= '0;
            drain_sel   <= '0;
            gate_sel    <= '0;
            prog_en     <= 1'b0;
            vinj_pulse  <= 1'b0;
            vtun_pulse  <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            pulses_used <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        mode_q      <= cmd_erase ? MODE_ERASE : MODE_INJECT;
                        n_q         <= cmd_pulses;
                        err_pend    <= 1'b0;
                        pulses_used <= '0;
                        if (cmd_illegal) begin
                            state <= StDone;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= StSetup;
                            prog_en <= 1'b1;
                            if (!cmd_erase) begin
                                dec_row   <= cmd_row;
                                dec_col   <= cmd_col;
                                drain_sel <= ROWS'(1) << cmd_row;
                                gate_sel  <= COLS'(1) << cmd_col;
                            end
                        end
                    end
                end
                StSetup: begin
                    if (tmr_zero) begin
                        state      <= StPulse;
                        vinj_pulse <= (mode_q == MODE_INJECT);
                        vtun_pulse <= (mode_q == MODE_ERASE);
                    end
                end
                StPulse: begin
                    if (tmr_zero) begin
                        state       <= StRecover;
                        vinj_pulse  <= 1'b0;
                        vtun_pulse  <= 1'b0;
                        pulses_used <= pulses_inc;
                    end
                end
                StRecover: begin
                    if (tmr_zero) begin
                        if (last_pulse) begin
                            state     <= StRelease;
                            err_pend  <= rb_fail;
                            dec_row   <= '0;
                            dec_col   <= '0;
                            drain_sel <= '0;
                            gate_sel  <= '0;
                        end else begin
                            state      <= StPulse;
                            vinj_pulse <= (mode_q == MODE_INJECT);
                            vtun_pulse <= (mode_q == MODE_ERASE);
                        end
                    end
                end
                StRelease: begin
                    if (tmr_zero) begin
                        state   <= StDone;
                        prog_en <= 1'b0;
                        done    <= 1'b1;
                        err     <= err_pend;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fg_island_prog_seq.sv
// Directed self-checking bench for fg_island_prog_seq (readback cases need FG_PROG_READBACK_EN).
module tb_fg_island_prog_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: ROWS=8, COLS=17, SETTLE=4, PULSE=16
    logic        cmd_valid, cmd_ready, cmd_erase, cmp_in;
    logic [2:0]  cmd_row, dec_row;
    logic [4:0]  cmd_col, dec_col;
    logic [7:0]  cmd_pulses, pulses_used, drain_sel;
    logic [16:0] gate_sel;
    logic        prog_en, vinj_pulse, vtun_pulse, busy, done, err;

    fg_island_prog_seq #(
        .ROWS       (8),
        .COLS       (17),
        .SETTLE_CYC (4),
        .PULSE_CYC  (16)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .cmd_pulses  (cmd_pulses),
        .cmd_erase   (cmd_erase),
        .cmp_in      (cmp_in),
        .dec_row     (dec_row),
        .dec_col     (dec_col),
        .drain_sel   (drain_sel),
        .gate_sel    (gate_sel),
        .prog_en     (prog_en),
        .vinj_pulse  (vinj_pulse),
        .vtun_pulse  (vtun_pulse),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .pulses_used (pulses_used)
    );

    // Small instance: ROWS=6 makes an out-of-range row expressible; minimum timings.
    logic       s_valid, s_ready, s_erase, s_cmp, s_prog, s_inj, s_tun, s_busy, s_done, s_err;
    logic [2:0] s_row, s_dec_row;
    logic [1:0] s_col, s_dec_col;
    logic [7:0] s_pulses, s_pu;
    logic [5:0] s_drain;
    logic [2:0] s_gate;

    fg_island_prog_seq #(
        .ROWS       (6),
        .COLS       (3),
        .SETTLE_CYC (1),
        .PULSE_CYC  (1)
    ) u_dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (s_valid),
        .cmd_ready   (s_ready),
        .cmd_row     (s_row),
        .cmd_col     (s_col),
        .cmd_pulses  (s_pulses),
        .cmd_erase   (s_erase),
        .cmp_in      (s_cmp),
        .dec_row     (s_dec_row),
        .dec_col     (s_dec_col),
        .drain_sel   (s_drain),
        .gate_sel    (s_gate),
        .prog_en     (s_prog),
        .vinj_pulse  (s_inj),
        .vtun_pulse  (s_tun),
        .busy        (s_busy),
        .done        (s_done),
        .err         (s_err),
        .pulses_used (s_pu)
    );

    int checks = 0;
    int failures = 0;

    int          r_lat, r_inj_rise, r_inj_high, r_tun_rise, r_tun_high, r_both;
    logic [7:0]  r_pu, r_drain_or;
    logic [16:0] r_gate_or;
    logic [2:0]  r_row_or;
    logic [4:0]  r_col_or;
    logic        r_err, r_prog_seen, r_prog_at_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({dec_row, dec_col, drain_sel, gate_sel, prog_en, vinj_pulse, vtun_pulse,
                    done, err, pulses_used});
    endfunction

    // Issue one command from IDLE, observe until done (or budget), return one cycle later.
    task automatic run_cmd(input logic [2:0] row, input logic [4:0] col, input logic [7:0] n,
                           input logic erase, input int cmp_after, input int max_cyc);
        logic prev_inj, prev_tun;
        int   inj_fall;
        cmd_row = row; cmd_col = col; cmd_pulses = n; cmd_erase = erase; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        r_lat = 0; r_inj_rise = 0; r_inj_high = 0; r_tun_rise = 0; r_tun_high = 0; r_both = 0;
        r_pu = '0; r_drain_or = '0; r_gate_or = '0; r_row_or = '0; r_col_or = '0;
        r_err = 1'b0; r_prog_seen = 1'b0; r_prog_at_done = 1'b1;
        prev_inj = 1'b0; prev_tun = 1'b0; inj_fall = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (vinj_pulse && !prev_inj) r_inj_rise++;
            if (!vinj_pulse && prev_inj) inj_fall++;
            if (vtun_pulse && !prev_tun) r_tun_rise++;
            if (vinj_pulse) r_inj_high++;
            if (vtun_pulse) r_tun_high++;
            if (vinj_pulse && vtun_pulse) r_both++;
            if (cmp_after != 0 && inj_fall == cmp_after) cmp_in = 1'b1;
            r_drain_or  = r_drain_or | drain_sel;
            r_gate_or   = r_gate_or | gate_sel;
            r_row_or    = r_row_or | dec_row;
            r_col_or    = r_col_or | dec_col;
            r_prog_seen = r_prog_seen | prog_en;
            if (done) begin
                r_lat = k; r_pu = pulses_used; r_err = err; r_prog_at_done = prog_en;
                break;
            end
            prev_inj = vinj_pulse;
            prev_tun = vtun_pulse;
            tick();
        end
        cmp_in = 1'b0;
        tick();
    endtask

    initial begin
        int k, rises, dcnt, d1, d2, rdy_cnt;
        logic [5:0] s_drain_or;
        logic [2:0] s_gate_or;

        cmd_valid = 0; cmd_row = 0; cmd_col = 0; cmd_pulses = 0; cmd_erase = 0; cmp_in = 0;
        s_valid = 0; s_row = 0; s_col = 0; s_pulses = 0; s_erase = 0; s_cmp = 0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outs", all_outs(), 64'd0);
        rst_n = 1'b1;
        tick();

        // Inject row 3, col 12, N=3: 2*4 + 3*20 + 1 = 69
        run_cmd(3'd3, 5'd12, 8'd3, 1'b0, 0, 200);
        chk("inj_latency", 64'(r_lat), 64'd69);
        chk("inj_pulses_used", 64'(r_pu), 64'd3);
        chk("inj_err", 64'(r_err), 64'd0);
        chk("inj_drain_sel", 64'(r_drain_or), 64'h08);
        chk("inj_gate_sel", 64'(r_gate_or), 64'h01000);
        chk("inj_dec_row", 64'(r_row_or), 64'd3);
        chk("inj_dec_col", 64'(r_col_or), 64'd12);
        chk("inj_vinj_count", 64'(r_inj_rise), 64'd3);
        chk("inj_vinj_cycles", 64'(r_inj_high), 64'd48);
        chk("inj_vtun_cycles", 64'(r_tun_high), 64'd0);
        chk("inj_prog_en_at_done", 64'(r_prog_at_done), 64'd0);
        chk("inj_ready_after", 64'(cmd_ready), 64'd1);

        // Erase, N=2: 8 + 40 + 1 = 49; addresses given must be ignored
        run_cmd(3'd5, 5'd7, 8'd2, 1'b1, 0, 200);
        chk("ers_latency", 64'(r_lat), 64'd49);
        chk("ers_vtun_count", 64'(r_tun_rise), 64'd2);
        chk("ers_vtun_cycles", 64'(r_tun_high), 64'd32);
        chk("ers_vinj_cycles", 64'(r_inj_high), 64'd0);
        chk("ers_selects", 64'({r_drain_or, r_gate_or, r_row_or, r_col_or}), 64'd0);
        chk("ers_prog_en_seen", 64'(r_prog_seen), 64'd1);
        chk("ers_pulses_used", 64'(r_pu), 64'd2);
        chk("ers_both_pulses", 64'(r_both), 64'd0);

        // Illegal column and N=0: done at T0+1 with err, nothing toggles
        run_cmd(3'd0, 5'd17, 8'd5, 1'b0, 0, 10);
        chk("ill_col_latency", 64'(r_lat), 64'd1);
        chk("ill_col_err", 64'(r_err), 64'd1);
        chk("ill_col_pulses_used", 64'(r_pu), 64'd0);
        chk("ill_col_prog_en", 64'(r_prog_seen), 64'd0);
        run_cmd(3'd2, 5'd2, 8'd0, 1'b0, 0, 10);
        chk("ill_n0_latency", 64'(r_lat), 64'd1);
        chk("ill_n0_err", 64'(r_err), 64'd1);
        chk("ill_n0_quiet", 64'({r_prog_seen, r_drain_or, r_gate_or, 6'(r_inj_high)}), 64'd0);

        // Illegal row on the small instance (ROWS=6)
        s_row = 3'd6; s_col = 2'd0; s_pulses = 8'd1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("ill_row_done", 64'(s_done), 64'd1);
        chk("ill_row_err", 64'(s_err), 64'd1);
        chk("ill_row_prog_en", 64'(s_prog), 64'd0);
        tick();
        chk("ill_row_done_once", 64'(s_done), 64'd0);
        tick();
        s_row = 3'd1; s_col = 2'd3; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("ill_col3_small", 64'({s_done, s_err, s_prog}), 64'b110);
        tick();
        tick();

        // Small legal inject, SETTLE=PULSE=1, N=1: 2 + 2 + 1 = 5
        s_row = 3'd5; s_col = 2'd2; s_pulses = 8'd1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        k = 0; s_drain_or = '0; s_gate_or = '0;
        for (int i = 1; i <= 20; i++) begin
            s_drain_or = s_drain_or | s_drain;
            s_gate_or  = s_gate_or | s_gate;
            if (s_done) begin
                k = i;
                break;
            end
            tick();
        end
        chk("small_latency", 64'(k), 64'd5);
        chk("small_selects", 64'({s_drain_or, s_gate_or}), 64'({6'h20, 3'b100}));
        chk("small_err", 64'(s_err), 64'd0);
        tick();

`ifdef FG_PROG_READBACK_EN
        // Comparator trips after pulse 4: 8 + 4*20 + 1 = 89
        run_cmd(3'd1, 5'd1, 8'd10, 1'b0, 4, 400);
        chk("rb_hit_pulses_used", 64'(r_pu), 64'd4);
        chk("rb_hit_err", 64'(r_err), 64'd0);
        chk("rb_hit_latency", 64'(r_lat), 64'd89);
        // Comparator never trips: 8 + 10*20 + 1 = 209
        run_cmd(3'd1, 5'd1, 8'd10, 1'b0, 0, 400);
        chk("rb_miss_pulses_used", 64'(r_pu), 64'd10);
        chk("rb_miss_err", 64'(r_err), 64'd1);
        chk("rb_miss_latency", 64'(r_lat), 64'd209);
`else
        // Comparator is ignored: exactly N pulses even with cmp_in raised
        run_cmd(3'd1, 5'd1, 8'd10, 1'b0, 4, 400);
        chk("norb_pulses_used", 64'(r_pu), 64'd10);
        chk("norb_err", 64'(r_err), 64'd0);
        chk("norb_latency", 64'(r_lat), 64'd209);
`endif

        // Reset during the second pulse
        cmd_row = 3'd2; cmd_col = 5'd4; cmd_pulses = 8'd3; cmd_erase = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        rises = 0;
        for (int i = 0; i < 200; i++) begin
            if (vinj_pulse) begin
                rises++;
                if (rises == 2) break;
                while (vinj_pulse) tick();
            end
            tick();
        end
        tick();
        tick();
        chk("mid_in_pulse", 64'(vinj_pulse), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_outs", all_outs(), 64'd0);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("mid_no_done", 64'(dcnt), 64'd0);
        chk("mid_ready_after", 64'(cmd_ready), 64'd1);
        chk("mid_prog_en_after", 64'(prog_en), 64'd0);

        // Back-to-back with cmd_valid held: N=1 -> 29 cycles each
        cmd_row = 3'd1; cmd_col = 5'd1; cmd_pulses = 8'd1; cmd_erase = 1'b0; cmd_valid = 1'b1;
        d1 = 0; d2 = 0; dcnt = 0; rdy_cnt = 0;
        for (int s = 1; s <= 70; s++) begin
            tick();
            if (done) begin
                dcnt++;
                if (dcnt == 1) d1 = s;
                if (dcnt == 2) d2 = s;
            end
            if (cmd_ready && s <= 58) rdy_cnt++;
            if (s == 31) cmd_valid = 1'b0;
        end
        chk("b2b_done1", 64'(d1), 64'd29);
        chk("b2b_done2", 64'(d2), 64'd59);
        chk("b2b_ready_windows", 64'(rdy_cnt), 64'd1);
        chk("b2b_done_count", 64'(dcnt), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
